// File: rtl/mul_pipe_param.sv
// mul_pipe_param: RV32M/RV64M multiply unit for the execute stage.
// LATENCY-deep pipeline that closes bubbles while writeback is stalled.
module mul_pipe_param #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 5,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_valid_in,
    input  logic [2:0]       mul_funct3_in,
    input  logic [XLEN-1:0]  mul_rs1_in,
    input  logic [XLEN-1:0]  mul_rs2_in,
    input  logic [TAG_W-1:0] mul_tag_in,
    input  logic             kill_mul,
    input  logic             stall_mul_in,
    output logic             stall_mul_out,
    output logic             mul_valid_out,
    output logic [XLEN-1:0]  mul_result_out,
    output logic [TAG_W-1:0] mul_tag_out,
    output logic             mul_busy_out
);

    localparam int L = LATENCY;
    localparam int PW = 2 * XLEN;

    logic [L-1:0]     r_vld;
    logic [TAG_W-1:0] r_tag [L];

    logic [L-1:0]     w_adv;
    logic             w_legal;
    logic             w_acc;
    logic             w_sx_a;
    logic             w_sx_b;
    logic             w_hi;
    logic [PW-1:0]    w_opa;
    logic [PW-1:0]    w_opb;
    logic [XLEN-1:0]  w_out_res;

    // Operand extension: MULH/MULHSU sign-extend rs1, only MULH
    // sign-extends rs2. The low 2*XLEN bits of the product of the
    // 2*XLEN-bit extended operands equal the signed product.
    assign w_sx_a = (mul_funct3_in[1:0] == 2'b01)
                  | (mul_funct3_in[1:0] == 2'b10);
    assign w_sx_b = (mul_funct3_in[1:0] == 2'b01);
    assign w_hi   = (mul_funct3_in[1:0] != 2'b00);

    assign w_opa = {{XLEN{w_sx_a & mul_rs1_in[XLEN-1]}}, mul_rs1_in};
    assign w_opb = {{XLEN{w_sx_b & mul_rs2_in[XLEN-1]}}, mul_rs2_in};

    assign w_legal = mul_valid_in & ~mul_funct3_in[2];

    // A stage may advance when it or any younger-facing stage ahead of
    // it is empty, or when writeback drains the last stage.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            w_adv[i] = !stall_mul_in;
            for (int j = i; j < L; j++) begin
                if (!r_vld[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign w_acc         = w_legal & w_adv[0] & ~kill_mul;
    assign stall_mul_out = w_legal & ~w_adv[0] & ~kill_mul;

    // Valid bits: reset and kill flush everything, else compact forward.
    always_ff @(posedge clk) begin
        if (rst || kill_mul) begin
            r_vld <= '0;
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= w_acc;
            end
            for (int i = 1; i < L; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end
    end

    // Tag pipeline, moves in lockstep with the valid bits.
    always_ff @(posedge clk) begin
        if (w_adv[0]) begin
            r_tag[0] <= mul_tag_in;
        end
        for (int i = 1; i < L; i++) begin
            if (w_adv[i]) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    generate
        if (L == 1) begin : g_single
            logic [PW-1:0]   w_prod;
            logic [XLEN-1:0] w_res;
            logic [XLEN-1:0] r_res;

            assign w_prod = w_opa * w_opb;
            assign w_res  = w_hi ? w_prod[PW-1:XLEN] : w_prod[XLEN-1:0];

            // Single stage: the whole product is formed before S[0].
            always_ff @(posedge clk) begin
                if (w_adv[0]) begin
                    r_res <= w_res;
                end
            end

            assign w_out_res = r_res;
        end else begin : g_multi
            logic [PW-1:0]   r_opa;
            logic [PW-1:0]   r_opb;
            logic            r_hi;
            logic [PW-1:0]   w_prod;
            logic [XLEN-1:0] w_res;
            logic [XLEN-1:0] r_res [1:L-1];

            // S[0] registers the extended operands so the multiplier
            // starts from flops instead of the operand bypass network.
            always_ff @(posedge clk) begin
                if (w_adv[0]) begin
                    r_opa <= w_opa;
                    r_opb <= w_opb;
                    r_hi  <= w_hi;
                end
            end

            assign w_prod = r_opa * r_opb;
            assign w_res  = r_hi ? w_prod[PW-1:XLEN] : w_prod[XLEN-1:0];

            // S[1] captures the product; later stages just carry it.
            always_ff @(posedge clk) begin
                if (w_adv[1]) begin
                    r_res[1] <= w_res;
                end
                for (int i = 2; i < L; i++) begin
                    if (w_adv[i]) begin
                        r_res[i] <= r_res[i-1];
                    end
                end
            end

            assign w_out_res = r_res[L-1];
        end
    endgenerate

    assign mul_valid_out  = r_vld[L-1];
    assign mul_result_out = r_vld[L-1] ? w_out_res : '0;
    assign mul_tag_out    = r_vld[L-1] ? r_tag[L-1] : '0;
    assign mul_busy_out   = |r_vld;

endmodule

// File: tb/tb_mul_pipe_param.sv
// tb_mul_pipe_param: scoreboard bench for mul_pipe_param.
// Two instances: XLEN=32/LATENCY=5 and XLEN=64/LATENCY=1.
module tb_mul_pipe_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v0, k0, s0_in;
    logic [2:0]  f0;
    logic [31:0] a0, b0;
    logic [4:0]  t0;
    logic        so0, vo0, busy0;
    logic [31:0] ro0;
    logic [4:0]  to0;

    logic        v1, k1, s1_in;
    logic [2:0]  f1;
    logic [63:0] a1, b1;
    logic [4:0]  t1;
    logic        so1, vo1, busy1;
    logic [63:0] ro1;
    logic [4:0]  to1;

    mul_pipe_param #(.XLEN(32), .LATENCY(5), .TAG_W(5)) u0 (
        .clk(clk), .rst(rst),
        .mul_valid_in(v0), .mul_funct3_in(f0),
        .mul_rs1_in(a0), .mul_rs2_in(b0), .mul_tag_in(t0),
        .kill_mul(k0), .stall_mul_in(s0_in),
        .stall_mul_out(so0), .mul_valid_out(vo0),
        .mul_result_out(ro0), .mul_tag_out(to0),
        .mul_busy_out(busy0)
    );

    mul_pipe_param #(.XLEN(64), .LATENCY(1), .TAG_W(5)) u1 (
        .clk(clk), .rst(rst),
        .mul_valid_in(v1), .mul_funct3_in(f1),
        .mul_rs1_in(a1), .mul_rs2_in(b1), .mul_tag_in(t1),
        .kill_mul(k1), .stall_mul_in(s1_in),
        .stall_mul_out(so1), .mul_valid_out(vo1),
        .mul_result_out(ro1), .mul_tag_out(to1),
        .mul_busy_out(busy1)
    );

    typedef struct {
        logic [63:0] res;
        logic [7:0]  tag;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   base = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor for the 32-bit, 5-stage instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vo0) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u0_unexpected: got valid tag %0h res %0h expected none",
                             to0, ro0);
                end else begin
                    chk("u0_res", 64'(ro0), q0[0].res);
                    chk("u0_tag", 64'(to0), 64'(q0[0].tag));
                    if (!s0_in) begin
                        chk("u0_cyc", 64'(cyc), 64'(q0[0].cyc));
                        void'(q0.pop_front());
                    end
                end
            end else begin
                chk("u0_gate", {27'd0, to0, ro0}, 64'd0);
            end
        end
    end

    // Monitor for the 64-bit, single-stage instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vo1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u1_unexpected: got valid tag %0h res %0h expected none",
                             to1, ro1);
                end else begin
                    chk("u1_res", ro1, q1[0].res);
                    chk("u1_tag", 64'(to1), 64'(q1[0].tag));
                    if (!s1_in) begin
                        chk("u1_cyc", 64'(cyc), 64'(q1[0].cyc));
                        void'(q1.pop_front());
                    end
                end
            end else begin
                chk("u1_gate", ro1 | 64'(to1), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(int c);
        while (cyc < base + c) step();
    endtask

    task automatic begin_test();
        step();
        base = cyc;
    endtask

    task automatic op0(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                       logic [4:0] t);
        v0 = 1'b1; f0 = f; a0 = a; b0 = b; t0 = t;
    endtask

    task automatic idle0();
        v0 = 1'b0; f0 = 3'd0; a0 = '0; b0 = '0; t0 = '0;
    endtask

    task automatic exp0(logic [63:0] r, logic [7:0] t, int c);
        q0.push_back('{res: r, tag: t, cyc: base + c});
    endtask

    task automatic op1(logic [2:0] f, logic [63:0] a, logic [63:0] b,
                       logic [4:0] t);
        v1 = 1'b1; f1 = f; a1 = a; b1 = b; t1 = t;
    endtask

    task automatic idle1();
        v1 = 1'b0; f1 = 3'd0; a1 = '0; b1 = '0; t1 = '0;
    endtask

    task automatic exp1(logic [63:0] r, logic [7:0] t, int c);
        q1.push_back('{res: r, tag: t, cyc: base + c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        k0 = 1'b0; s0_in = 1'b0; idle0();
        k1 = 1'b0; s1_in = 1'b0; idle1();
        repeat (3) step();
        rst = 1'b0;
        chk("rst_valid0", 64'(vo0), 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_res0", 64'(ro0), 64'd0);
        chk("rst_valid1", 64'(vo1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        mon_en = 1'b1;

        // Single MULHU, exact latency and one-cycle valid.
        begin_test();
        op0(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        exp0(64'hFFFF_FFFE, 8'd3, 5);
        at(1); idle0();
        at(3); chk("t1_busy", 64'(busy0), 64'd1);
        at(5); chk("t1_valid_c5", 64'(vo0), 64'd1);
        at(6); chk("t1_valid_c6", 64'(vo0), 64'd0);

        // Back-to-back ops of every legal funct3.
        begin_test();
        op0(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        exp0(64'h0000_0001, 8'd1, 5);
        at(1);
        op0(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2);
        exp0(64'h4000_0000, 8'd2, 6);
        at(2);
        op0(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        exp0(64'hFFFF_FFFF, 8'd3, 7);
        at(3);
        op0(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        exp0(64'h0000_0000, 8'd4, 8);
        at(4); idle0();
        at(10); chk("t2_drain", 64'(q0.size()), 64'd0);

        // Output stall: A held, B compacts behind and follows at 11.
        begin_test();
        op0(3'b000, 32'd3, 32'd5, 5'd7);
        exp0(64'd15, 8'd7, 10);
        at(1); idle0();
        at(2);
        op0(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd8);
        exp0(64'd1, 8'd8, 11);
        at(3); idle0();
        at(5); s0_in = 1'b1;
        at(10); s0_in = 1'b0;
        at(12); chk("t3_drain", 64'(q0.size()), 64'd0);

        // Fill all five stages under stall, then back-pressure.
        begin_test();
        s0_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            at(k);
            op0(3'b000, 32'(k + 2), 32'd3, 5'(10 + k));
            exp0(64'((k + 2) * 3), 8'(10 + k), 7 + k);
            #1 chk("t3b_accept", 64'(so0), 64'd0);
        end
        at(5);
        op0(3'b000, 32'd100, 32'd100, 5'd20);
        exp0(64'd10000, 8'd20, 12);
        #1 chk("t3b_stall_c5", 64'(so0), 64'd1);
        chk("t3b_busy_c5", 64'(busy0), 64'd1);
        at(6);
        #1 chk("t3b_stall_c6", 64'(so0), 64'd1);
        at(7); s0_in = 1'b0;
        #1 chk("t3b_stall_c7", 64'(so0), 64'd0);
        at(8); idle0();
        at(14); chk("t3b_drain", 64'(q0.size()), 64'd0);

        // Kill with three ops in flight and a legal op offered.
        begin_test();
        op0(3'b000, 32'd1, 32'd1, 5'd1);
        at(1); op0(3'b000, 32'd2, 32'd1, 5'd2);
        at(2); op0(3'b000, 32'd3, 32'd1, 5'd3);
        at(3);
        op0(3'b000, 32'd4, 32'd1, 5'd4);
        k0 = 1'b1; s0_in = 1'b1;
        #1 chk("t4_stall_kill", 64'(so0), 64'd0);
        chk("t4_busy_c3", 64'(busy0), 64'd1);
        at(4); k0 = 1'b0; s0_in = 1'b0; idle0();
        chk("t4_busy_c4", 64'(busy0), 64'd0);
        chk("t4_valid_c4", 64'(vo0), 64'd0);
        at(12);

        // Kill beats stall with a full pipeline.
        begin_test();
        s0_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            at(k);
            op0(3'b000, 32'd9, 32'(k + 1), 5'(k + 1));
            if (k == 0) exp0(64'd9, 8'd1, 99);
        end
        at(5);
        op0(3'b000, 32'd5, 32'd5, 5'd6);
        k0 = 1'b1;
        #1 chk("t4b_stall_kill", 64'(so0), 64'd0);
        chk("t4b_valid_kill", 64'(vo0), 64'd1);
        at(6); k0 = 1'b0; s0_in = 1'b0; idle0();
        q0.delete();
        chk("t4b_valid_c6", 64'(vo0), 64'd0);
        chk("t4b_busy_c6", 64'(busy0), 64'd0);
        at(12);

        // Synchronous reset under stall, then normal service.
        begin_test();
        s0_in = 1'b1;
        op0(3'b000, 32'd11, 32'd2, 5'd1);
        at(1); op0(3'b000, 32'd12, 32'd2, 5'd2);
        at(2); idle0(); rst = 1'b1;
        at(3); rst = 1'b0; s0_in = 1'b0;
        chk("t5_valid_c3", 64'(vo0), 64'd0);
        chk("t5_busy_c3", 64'(busy0), 64'd0);
        at(4);
        op0(3'b000, 32'd7, 32'd6, 5'd9);
        exp0(64'd42, 8'd9, 9);
        at(5); idle0();
        at(11); chk("t5_drain", 64'(q0.size()), 64'd0);

        // Divide-class funct3 is ignored.
        begin_test();
        op0(3'b100, 32'd20, 32'd5, 5'd6);
        #1 chk("t6_stall_c0", 64'(so0), 64'd0);
        at(1);
        chk("t6_busy_c1", 64'(busy0), 64'd0);
        op0(3'b111, 32'd20, 32'd5, 5'd7);
        #1 chk("t6_stall_c1", 64'(so0), 64'd0);
        at(2);
        chk("t6_busy_c2", 64'(busy0), 64'd0);
        idle0();
        at(8);

        // 64-bit single-stage instance.
        begin_test();
        op1(3'b011, 64'h8000_0000_0000_0000, 64'd2, 5'd5);
        exp1(64'd1, 8'd5, 1);
        at(1);
        op1(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6);
        exp1(64'hFFFF_FFFF_FFFF_FFFF, 8'd6, 2);
        at(2);
        op1(3'b000, 64'h0000_0001_0000_0001,
            64'h0000_0001_0000_0001, 5'd7);
        exp1(64'h0000_0002_0000_0001, 8'd7, 3);
        at(3);
        op1(3'b011, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
        exp1(64'hFFFF_FFFF_FFFF_FFFE, 8'd8, 5);
        at(4);
        s1_in = 1'b1;
        op1(3'b000, 64'd3, 64'd4, 5'd9);
        exp1(64'd12, 8'd9, 6);
        #1 chk("t7_stall_c4", 64'(so1), 64'd1);
        at(5); s1_in = 1'b0;
        #1 chk("t7_stall_c5", 64'(so1), 64'd0);
        at(6); idle1();
        at(8); chk("t7_drain", 64'(q1.size()), 64'd0);

        step();
        chk("final_q0", 64'(q0.size()), 64'd0);
        chk("final_q1", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_pipe_param.md
Name: mul_pipe_param

Overview:
- Parametrised RV32M/RV64M multiply unit for the execute stage.
- Accepts MUL/MULH/MULHSU/MULHU and computes the real product through a LATENCY-stage pipeline. Each entry carries a destination tag.
- Handshakes with writeback using the stall_mul_in / stall_mul_out convention. Supports a global kill from the graduation logic.
- Unlike a plain shift-register pipeline, it collapses bubbles: younger ops advance into empty slots while the output is stalled.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- LATENCY, 5, cycles from accept to result valid; legal range 1..8.
- TAG_W, 5, width of the destination tag carried with each op.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- mul_valid_in  input  1  op offered this cycle.
- mul_funct3_in  input  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- mul_rs1_in  input  XLEN  operand A.
- mul_rs2_in  input  XLEN  operand B.
- mul_tag_in  input  TAG_W  destination tag.
- kill_mul  input  1  flush all in-flight ops.
- stall_mul_in  input  1  writeback not consuming output this cycle.
- stall_mul_out  output  1  offered op not accepted this cycle; upstream must hold it.
- mul_valid_out  output  1  result valid.
- mul_result_out  output  XLEN  result.
- mul_tag_out  output  TAG_W  tag of result.
- mul_busy_out  output  1  any stage holds a valid op.

Behaviour:
- State: stages S[0..LATENCY-1]. Each stage holds valid, funct3, tag and product/partial data. Outputs are driven from S[LATENCY-1].
- Legal op: mul_valid_in=1 and funct3[2]=0. Ops with funct3[2]=1 are ignored, never enter S[0], and raise no stall.
- Advance rule:
  - adv[L-1] = !valid[L-1] | !stall_mul_in.
  - adv[i] = !valid[i] | adv[i+1].
  - If adv[i] and i>0, S[i] loads S[i-1]. Otherwise S[i] holds.
  - If adv[i] and valid[i-1]=0, S[i] becomes invalid (bubble).
- Accept: a legal op is accepted when adv[0]=1 and kill_mul=0; S[0] loads it at the edge.
- stall_mul_out = legal op & !adv[0] & !kill_mul. It is combinational and depends on stall_mul_in.
- Latency: with no stalls, an op accepted in cycle N shows mul_valid_out=1 in cycle N+LATENCY for exactly one cycle.
- Held output: while stall_mul_in=1 and valid[L-1]=1, mul_valid_out, result and tag stay constant.
- Arithmetic: take the 2*XLEN-bit product of (XLEN+1)-bit extended operands.
  - rs1 is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - rs2 is sign-extended for MULH only.
  - MUL returns product[XLEN-1:0]; the others return product[2XLEN-1:XLEN].
  - How the multiply is split across stages is free. Result correctness and the exact latency are mandatory.
- Output gating: mul_result_out and mul_tag_out read 0 when mul_valid_out=0.
- mul_busy_out = OR of all valid bits.
- Kill: kill_mul=1 clears every valid bit at the edge and drops any input offered that cycle. During the kill cycle mul_valid_out still reflects the current S[L-1], and it is 0 from the next cycle.
- Kill with stall: kill_mul wins over stall_mul_in.
- Reset: rst=1 clears all valid bits at the edge, regardless of kill or stall. Outputs are 0 the cycle after.
  - Reset mid-operation discards all in-flight ops.
  - Data registers need no reset.
- Throughput: one op per cycle when unstalled. While stalled, up to LATENCY ops can be held; further legal ops see stall_mul_out=1.
- LATENCY=1: single stage; stall_mul_out = legal & valid[0] & stall_mul_in.

Test Plan:
- XLEN=32, LATENCY=5. Issue MULHU 0xFFFFFFFF*0xFFFFFFFF tag 3 in cycle 0 → cycle 5: valid_out=1, result 0xFFFFFFFE, tag 3. Cycle 6: valid_out=0.
- Back-to-back ops in cycles 0-3:
  - MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
  - MULH 0x80000000*0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
  - Results appear in cycles 5-8 in order.
- Issue op A in cycle 0, hold stall_mul_in=1 in cycles 5-9, issue op B in cycle 2 → A is held on the output in cycles 5-9 and B compacts behind it. After the stall releases, B is valid in cycle 11 (not 7). Legal ops offered with S[0..4] all full see stall_mul_out=1.
- Three ops in flight, kill_mul=1 in cycle 3 with a legal op offered the same cycle → no valid_out afterwards, stall_mul_out=0 in cycle 3, busy_out=0 from cycle 4.
- rst=1 in cycle 2 with two ops in flight and stall_mul_in=1 → valid_out=0 and busy_out=0 from cycle 3. An op issued in cycle 4 returns in cycle 9.
- Offer funct3=100 (DIV) → never accepted, no valid_out, stall_mul_out stays 0.
- LATENCY=1 and XLEN=64: MULHU 2^63*2 → 0x1, valid in the next cycle.
